// File: rtl/display_scan_arbiter.sv
// Shared 4-digit multiplexed display owner: grants the display to one service,
// scans digits with a programmable divider and applies per-digit blink masks.
module display_scan_arbiter #(
  parameter int unsigned SCAN_DIV  = 65536,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  svc_sel,
  input  logic [63:0] num_bus,
  input  logic [15:0] blink_bus,
  input  logic        force_blank,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic [3:0]  grant,
  output logic        frame_start
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    grant_q, grant_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    digit_q, digit_d;
  logic          frame_start_q, frame_start_d;

  logic          sel_valid;
  logic          scan_tc;
  logic          wrap;
  logic          blink_tc;
  logic          blank_now;
  logic [15:0]   owner_num;
  logic [3:0]    owner_blink;

  always_comb begin
    sel_valid     = $onehot(svc_sel);
    scan_tc       = (div_cnt_q == SCAN_LAST);
    wrap          = scan_tc && (idx_q == 2'd3);

    div_cnt_d     = scan_tc ? '0 : div_cnt_q + 1'b1;
    idx_d         = scan_tc ? idx_q + 2'd1 : idx_q;
    grant_d       = grant_q;
    frame_start_d = wrap;

    // An idle display is adopted immediately; an owned one only changes hands
    // at the frame boundary so a frame is never split between two services.
    if (grant_q == 4'b0000) begin
      if (sel_valid) begin
        grant_d       = svc_sel;
        idx_d         = 2'd0;
        div_cnt_d     = '0;
        frame_start_d = 1'b1;
      end
    end else if (wrap) begin
      grant_d = sel_valid ? svc_sel : 4'b0000;
    end

    blink_tc      = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_tc ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_tc;

    case (grant_q)
      4'b1000: begin owner_num = num_bus[63:48]; owner_blink = blink_bus[15:12]; end
      4'b0100: begin owner_num = num_bus[47:32]; owner_blink = blink_bus[11:8];  end
      4'b0010: begin owner_num = num_bus[31:16]; owner_blink = blink_bus[7:4];   end
      4'b0001: begin owner_num = num_bus[15:0];  owner_blink = blink_bus[3:0];   end
      default: begin owner_num = 16'h0000;       owner_blink = 4'b0000;          end
    endcase

    blank_now = (grant_q == 4'b0000) || force_blank || (blink_phase_q && owner_blink[idx_q]);
    anode_d   = blank_now ? 4'b1111 : ~(4'b0001 << idx_q);
    digit_d   = blank_now ? 4'h0 : owner_num[{idx_q, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q     <= '0;
      idx_q         <= 2'd0;
      grant_q       <= 4'b0000;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      anode_q       <= 4'b1111;
      digit_q       <= 4'h0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      grant_q       <= grant_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anode_q       <= anode_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign digit       = digit_q;
  assign grant       = grant_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Bench for display_scan_arbiter: frame-position/cycle-count model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_display_scan_arbiter;

  localparam int SD = 4;
  localparam int BD = 16;

  logic        clk;
  logic        resetn;
  logic [3:0]  svc_sel;
  logic [63:0] num_bus;
  logic [15:0] blink_bus;
  logic        force_blank;
  logic [3:0]  anode;
  logic [3:0]  digit;
  logic [3:0]  grant;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  display_scan_arbiter #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .svc_sel     (svc_sel),
    .num_bus     (num_bus),
    .blink_bus   (blink_bus),
    .force_blank (force_blank),
    .anode       (anode),
    .digit       (digit),
    .grant       (grant),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the 4*SD-cycle frame, and cycles since reset release
  // (which alone determines the blink phase).
  int         m_pos;
  int         m_k;
  int         m_idx;
  int         m_phase;
  logic [3:0] m_grant;
  logic [3:0] m_an;
  logic [3:0] m_dg;
  logic       m_fs;
  logic [15:0] m_own_n;
  logic [3:0]  m_own_b;
  logic        m_blank;
  logic        m_valid;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pos = 0; m_k = 0; m_grant = 4'h0; m_an = 4'hF; m_dg = 4'h0; m_fs = 1'b0;
    end else begin
      m_idx   = m_pos / SD;
      m_phase = (m_k / BD) % 2;
      m_own_n = 16'h0;
      m_own_b = 4'h0;
      for (int s = 0; s < 4; s++)
        if (m_grant[s]) begin
          m_own_n = num_bus[16*s +: 16];
          m_own_b = blink_bus[4*s +: 4];
        end
      m_blank = (m_grant == 4'h0) || force_blank || (m_phase == 1 && m_own_b[m_idx]);
      m_an    = m_blank ? 4'hF : ~(4'b0001 << m_idx);
      m_dg    = m_blank ? 4'h0 : m_own_n[4*m_idx +: 4];
      m_valid = ($countones(svc_sel) == 1);
      if (m_grant == 4'h0 && m_valid) begin
        m_grant = svc_sel; m_pos = 0; m_fs = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % (4 * SD);
        m_fs  = (m_pos == 0);
        if (m_fs) m_grant = m_valid ? svc_sel : 4'h0;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("model_anode", anode, m_an);
      chk("model_digit", digit, m_dg);
      chk("model_grant", grant, m_grant);
      chk("model_frame_start", {3'b0, frame_start}, {3'b0, m_fs});
    end
  end

  task automatic wait_fs(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_start) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting frame_start actual=0 required=1", nm);
    end
  endtask

  logic [3:0] exp_an [4];
  logic [3:0] exp_dg [4];
  int n_f, n_b, n_0, n_1, n_3;

  initial begin
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_dg = '{4'h4, 4'h3, 4'h2, 4'h1};
    num_bus     = {16'h1234, 16'h5678, 16'hF90A, 16'h0042};
    blink_bus   = 16'h0000;
    force_blank = 1'b0;
    svc_sel     = 4'b0000;
    resetn      = 1'b1;
    #1 resetn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anode", anode, 4'hF);
    chk("rst_digit", digit, 4'h0);
    chk("rst_grant", grant, 4'h0);
    chk("rst_fs", {3'b0, frame_start}, 4'h0);

    // Adoption of service 1 and one full frame
    resetn  = 1'b1;
    svc_sel = 4'b1000;
    @(negedge clk);
    chk("adopt_grant", grant, 4'b1000);
    chk("adopt_fs", {3'b0, frame_start}, 4'h1);
    chk("adopt_anode", anode, 4'hF);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk("scan_anode", anode, exp_an[(j-1)/4]);
      chk("scan_digit", digit, exp_dg[(j-1)/4]);
      chk("scan_fs", {3'b0, frame_start}, {3'b0, (j == 16)});
    end

    // Switch to service 3 mid-frame: held until the boundary
    repeat (5) @(negedge clk);
    svc_sel = 4'b0010;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (frame_start) got = 1'b1;
        else chk("switch_hold_grant", grant, 4'b1000);
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL switch timeout waiting frame_start actual=0 required=1");
      end
    end
    chk("switch_grant", grant, 4'b0010);
    chk("switch_last_anode", anode, 4'b0111);
    chk("switch_last_digit", digit, 4'h1);
    @(negedge clk);
    chk("svc3_anode", anode, 4'b1110);
    chk("svc3_digit_passthru", digit, 4'hA);

    // Invalid selection drops ownership at the boundary, then re-adoption
    svc_sel = 4'b1100;
    wait_fs("invalid");
    chk("invalid_grant", grant, 4'h0);
    @(negedge clk);
    chk("invalid_anode", anode, 4'hF);
    chk("invalid_digit", digit, 4'h0);
    svc_sel = 4'b0100;
    @(negedge clk);
    chk("readopt_grant", grant, 4'b0100);
    chk("readopt_fs", {3'b0, frame_start}, 4'h1);
    @(negedge clk);
    chk("svc2_anode", anode, 4'b1110);
    chk("svc2_digit", digit, 4'h8);

    // Blink digit 2 of service 1
    svc_sel = 4'b1000;
    wait_fs("to_svc1");
    chk("svc1_grant", grant, 4'b1000);
    blink_bus = 16'h4000;
    n_f = 0; n_b = 0; n_0 = 0; n_1 = 0; n_3 = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      case (anode)
        4'b1111: n_f++;
        4'b1011: n_b++;
        4'b1110: n_0++;
        4'b1101: n_1++;
        4'b0111: n_3++;
        default: ;
      endcase
    end
    chk("blink_blank_cnt", 4'(n_f), 4'd8);
    chk("blink_shown_cnt", 4'(n_b), 4'd8);
    chk("blink_d0_cnt", 5'(n_0) == 5'd16 ? 4'h1 : 4'h0, 4'h1);
    chk("blink_d1_cnt", 5'(n_1) == 5'd16 ? 4'h1 : 4'h0, 4'h1);
    chk("blink_d3_cnt", 5'(n_3) == 5'd16 ? 4'h1 : 4'h0, 4'h1);

    // Force blank for 10 cycles mid-frame
    blink_bus   = 16'h0000;
    repeat (3) @(negedge clk);
    force_blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("force_anode", anode, 4'hF);
    end
    force_blank = 1'b0;
    @(negedge clk);
    chk("force_release_onehot", 4'($countones(~anode)), 4'd1);

    // Asynchronous reset during the digit-2 slot
    begin
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (anode == 4'b1011) got = 1'b1;
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL find_slot2 timeout actual=%h required=b", anode);
      end
    end
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_anode", anode, 4'hF);
    chk("async_rst_grant", grant, 4'h0);
    chk("async_rst_digit", digit, 4'h0);
    svc_sel = 4'b0001;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", grant, 4'b0001);
    chk("post_rst_fs", {3'b0, frame_start}, 4'h1);
    @(negedge clk);
    chk("svc4_anode", anode, 4'b1110);
    chk("svc4_digit", digit, 4'h2);
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_arbiter.md
Name: display_scan_arbiter

Overview:
- Owns the shared 4-digit multiplexed 7-segment display and grants it to one of four services (time set, alarm set, stopwatch, alarm/mini-game), selected by the one-hot service switches.
- Scans digits with a programmable refresh divider and applies per-digit blink masks supplied by the owning service.
- Drives active-low anodes and the 4-bit digit code that feeds the number-to-segment decoder.
- Sits between the service blocks and the segment decoder in the top level.

Parameters:
- SCAN_DIV, 65536, clk cycles each digit stays lit (≥2).
- BLINK_DIV, 25000000, clk cycles per blink-phase toggle (≥2).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- svc_sel  input  4  service switches; bit3 = service 1, bit0 = service 4.
- num_bus  input  64  BCD digits; [63:48] service 1, [47:32] service 2, [31:16] service 3, [15:0] service 4; within each 16-bit field, [3:0] is the rightmost digit.
- blink_bus  input  16  per-digit blink enables, same service ordering; within each nibble, bit0 is the rightmost digit.
- force_blank  input  1  blanks the display (service finish); scanning continues.
- anode  output  4  active-low digit enables; bit0 is the rightmost digit.
- digit  output  4  BCD code for the segment decoder.
- grant  output  4  one-hot current owner; 0 means no owner.
- frame_start  output  1  one-cycle pulse when the digit-0 slot begins.

Behaviour:
- Reset (async, resetn=0) sets div_cnt=0, idx=0, grant=0, blink_phase=0, blink_cnt=0, anode=4'b1111, digit=0, frame_start=0.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1. At terminal count it returns to 0 and idx advances 0→1→2→3→0.
  - frame_start pulses on the cycle idx becomes 0, including on adoption (below).
- Ownership, with sel_valid = svc_sel has exactly one bit set:
  - Adoption: grant==0 and sel_valid → next cycle grant=svc_sel, idx=0, div_cnt=0, frame_start=1.
  - Switching: grant!=0 and svc_sel differs → grant is reloaded only at the 3→0 wrap (frame boundary). At that point it becomes svc_sel if sel_valid, else 0. No mid-frame tearing.
  - svc_sel returning to the current grant before the boundary → no change.
  - Multiple bits set or all zero → treated as not valid; grant drops to 0 at the next boundary.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase at terminal count.
  - blink_cnt runs freely, independent of grant.
- Outputs are registered, with 1-cycle latency from idx/grant/input values:
  - blank_now = (grant==0) | force_blank | (blink_phase & owner_blink[idx]).
  - anode = blank_now ? 4'b1111 : ~(4'b0001 << idx).
  - digit = blank_now ? 4'h0 : owner_num[4*idx+3 : 4*idx].
  - Exactly one anode bit is low when not blanked.
- Digit values above 9 are passed through unchanged; the decoder blanks them.
- Simultaneous events:
  - Terminal count on a frame boundary together with a selection change → the new grant and idx=0 take effect in the same cycle.
  - force_blank overrides blink.
- Reset mid-scan returns immediately to reset values. After release, the first adoption occurs one cycle after sel_valid.

Test Plan:
- SCAN_DIV=4, BLINK_DIV=16, reset, svc_sel=4'b1000, num_bus[63:48]=16'h1234 → grant=1000 next cycle, frame_start=1. anode 1110/1101/1011/0111 each for 4 cycles with digit 4,3,2,1. frame_start repeats every 16 cycles.
- With owner service 1 established, switch svc_sel to 4'b0010 during idx=1 → grant stays 1000 until the 3→0 wrap, then becomes 0010. Service 3 digits appear from the next frame.
- svc_sel=4'b1100 during a frame → grant=0 at the boundary, anode=1111, digit=0 thereafter. Setting svc_sel=4'b0100 → adoption next cycle.
- blink_bus[15:12]=4'b0100 with owner service 1 → digit-2 slot shows anode=1111 when blink_phase=1 and 1011 when blink_phase=0. Toggles every 16 cycles; other digits unaffected.
- force_blank=1 for 10 cycles mid-frame → anode=1111 throughout, idx keeps advancing. On release, anode matches the current idx one cycle later.
- Assert resetn=0 during idx=2 → anode=1111, grant=0 immediately, without waiting for a clock. After release with svc_sel=4'b0001 → grant=0001 and idx=0 one cycle later.
